// File: rtl/cdc_event_pkg.sv
// Shared state encoding and elaboration helpers for cdc_event_scheduler.
package cdc_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_RELEASE = 2'b10
    } state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or above ptr (with wrap);
// ptr moves past the winner whenever the grant input is asserted.
module rr_arbiter
    import cdc_event_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_grant,
    output logic [IDW-1:0]  o_winner,
    output logic            o_valid
);

    if (IDW < clog2(NREQ)) begin : g_bad_idw
        $error("rr_arbiter: IDW too narrow for NREQ");
    end

    localparam logic [IDW:0]   NREQ_W = (IDW + 1)'(NREQ);
    localparam logic [IDW-1:0] LAST   = IDW'(NREQ - 1);

    logic [IDW-1:0]  ptr;
    logic [NREQ-1:0] rotated;
    logic [IDW-1:0]  offset;
    logic [IDW:0]    sum;

    // NOTE: every variable written here gets a value before any condition,
    // otherwise synthesis infers a latch to hold it.
    always_comb begin
        rotated = NREQ'({i_req, i_req} >> ptr);
        offset  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IDW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
        end
        o_winner = sum[IDW-1:0];
        o_valid  = |i_req;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            ptr <= '0;
        end else if (i_grant) begin
            ptr <= (o_winner == LAST) ? '0 : o_winner + 1'b1;
        end
    end

endmodule

// File: rtl/cdc_event_scheduler.sv
// Shares one four-phase req/ack crossing among NREQ event requesters.
// Optional watchdog abort enabled by defining CDC_EVENT_SCHEDULER_WATCHDOG_EN.
module cdc_event_scheduler
    import cdc_event_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 1023,
    parameter int TOW     = 10
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic [NREQ-1:0] i_stb,
    input  logic [NREQ-1:0] i_clr_overrun,
    input  logic            i_ack,
    output logic            o_req,
    output logic [IDW-1:0]  o_id,
    output logic            o_busy,
    output logic            o_done,
    output logic [NREQ-1:0] o_pending,
    output logic [NREQ-1:0] o_overrun,
    output logic            o_timeout
);

    if (TOW < clog2(TIMEOUT + 1)) begin : g_bad_tow
        $error("cdc_event_scheduler: TOW too narrow for TIMEOUT");
    end

    state_e          state;
    state_e          state_next;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] overrun;
    logic [NREQ-1:0] grant_mask;
    logic [IDW-1:0]  winner;
    logic            any_valid;
    logic            grant;
    logic            done_next;
    logic            timeout_next;
    logic            wd_expired;
    logic            aborted;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arbiter (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_req     (pending),
        .i_grant   (grant),
        .o_winner  (winner),
        .o_valid   (any_valid)
    );

    // A high ack while idle is stale from the previous transaction; wait it out.
    assign grant      = (state == ST_IDLE) && any_valid && !i_ack;
    assign grant_mask = grant ? (NREQ'(1) << winner) : '0;

    always_comb begin
        state_next   = state;
        done_next    = 1'b0;
        timeout_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_ack) begin
                    state_next = ST_RELEASE;
                end else if (wd_expired) begin
                    state_next   = ST_RELEASE;
                    timeout_next = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!i_ack) begin
                    state_next = ST_IDLE;
                    done_next  = !aborted;
                end else if (wd_expired) begin
                    state_next   = ST_IDLE;
                    timeout_next = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef CDC_EVENT_SCHEDULER_WATCHDOG_EN
    localparam logic [TOW-1:0] WD_LAST = TOW'(TIMEOUT - 1);

    logic [TOW-1:0] wd_cnt;
    logic           aborted_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wd_cnt    <= '0;
            aborted_q <= 1'b0;
        end else begin
            if (state_next != state) begin
                wd_cnt <= '0;
            end else if (state != ST_IDLE) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            // Remember a REQ abort so the following release does not report done.
            if (state == ST_REQ && state_next == ST_RELEASE) begin
                aborted_q <= timeout_next;
            end
        end
    end

    assign wd_expired = (state != ST_IDLE) && (wd_cnt == WD_LAST);
    assign aborted    = aborted_q;
`else
    assign wd_expired = 1'b0;
    assign aborted    = 1'b0;
`endif

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state     <= ST_IDLE;
            pending   <= '0;
            overrun   <= '0;
            o_id      <= '0;
            o_req     <= 1'b0;
            o_done    <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            state     <= state_next;
            pending   <= (pending & ~grant_mask) | i_stb;
            overrun   <= (overrun & ~i_clr_overrun) | (i_stb & pending & ~grant_mask);
            if (grant) begin
                o_id <= winner;
            end
            o_req     <= (state_next == ST_REQ);
            o_done    <= done_next;
            o_timeout <= timeout_next;
        end
    end

    assign o_busy    = (state != ST_IDLE);
    assign o_pending = pending;
    assign o_overrun = overrun;

endmodule

// File: tb/tb_cdc_event_scheduler.sv
// Self-checking bench for cdc_event_scheduler: directed scenarios plus a random
// run, all checked against a set/queue-level model of the scheduling rules.
module tb_cdc_event_scheduler;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 8;
    localparam int TOW     = 4;
    localparam int VW      = 4 + IDW + 2 * NREQ;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] stb;
    logic [NREQ-1:0] clr;
    logic            ack;
    logic            req;
    logic [IDW-1:0]  id;
    logic            busy;
    logic            done;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] overrun;
    logic            timeout;

    int compared   = 0;
    int mismatched = 0;

    cdc_event_scheduler #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .TIMEOUT (TIMEOUT),
        .TOW     (TOW)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_stb         (stb),
        .i_clr_overrun (clr),
        .i_ack         (ack),
        .o_req         (req),
        .o_id          (id),
        .o_busy        (busy),
        .o_done        (done),
        .o_pending     (pending),
        .o_overrun     (overrun),
        .o_timeout     (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 idle, 1 requesting, 2 releasing.
    bit m_pend[NREQ];
    bit m_ovr[NREQ];
    int m_ptr, m_phase, m_id, m_dones;
    bit m_done;

    // Ack responder and observation bookkeeping.
    bit auto_ack, rand_delay, req_prev;
    int ack_delay, ack_cnt, cycle, dones;
    int grants[$];
    int diff_cnt, diff_cyc;
    logic [VW-1:0] diff_obs, diff_exp;

    function automatic int rr_pick();
        for (int k = 0; k < NREQ; k++) begin
            if (m_pend[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        m_done = 1'b0;
        if (!rst_n) begin
            for (int k = 0; k < NREQ; k++) begin
                m_pend[k] = 1'b0;
                m_ovr[k]  = 1'b0;
            end
            m_ptr = 0; m_phase = 0; m_id = 0;
            return;
        end
        w = (m_phase == 0 && !ack) ? rr_pick() : -1;
        for (int k = 0; k < NREQ; k++) begin
            if (stb[k] && m_pend[k] && w != k) m_ovr[k] = 1'b1;
            else if (clr[k])                   m_ovr[k] = 1'b0;
            m_pend[k] = stb[k] || (m_pend[k] && w != k);
        end
        case (m_phase)
            0: if (w >= 0) begin m_phase = 1; m_id = w; m_ptr = (w + 1) % NREQ; end
            1: if (ack) m_phase = 2;
            default: if (!ack) begin m_phase = 0; m_done = 1'b1; m_dones++; end
        endcase
    endtask

    function automatic logic [VW-1:0] exp_vec();
        logic [NREQ-1:0] p, o;
        for (int k = 0; k < NREQ; k++) begin
            p[k] = m_pend[k];
            o[k] = m_ovr[k];
        end
        return {m_phase == 1, IDW'(m_id), m_phase != 0, m_done, p, o, 1'b0};
    endfunction

    function automatic logic [VW-1:0] obs_vec();
        return {req, id, busy, done, pending, overrun, timeout};
    endfunction

    function automatic bit same_q(input int a[$], input int b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: advance the model on the pre-edge inputs, sample #1 after the
    // edge, then let the ack responder react for the next edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cycle++;
        if (obs_vec() !== exp_vec()) begin
            diff_cnt++;
            if (diff_cnt == 1) begin
                diff_cyc = cycle;
                diff_obs = obs_vec();
                diff_exp = exp_vec();
            end
        end
        if (req === 1'b1 && !req_prev) grants.push_back(int'(id));
        if (done === 1'b1) dones++;
        req_prev = (req === 1'b1);
        stb = '0;
        clr = '0;
        if (auto_ack) begin
            if (req !== ack) begin
                ack_cnt++;
                if (ack_cnt >= ack_delay) begin
                    ack     = (req === 1'b1);
                    ack_cnt = 0;
                    if (rand_delay) ack_delay = $urandom_range(1, 4);
                end
            end else begin
                ack_cnt = 0;
            end
        end
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (busy === 1'b0 && pending === '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic model_ok(input string name);
        compared++;
        if (diff_cnt != 0) begin
            mismatched++;
            $display("FAIL %s_model: %0d cycles differ, first at cycle %0d dut=%h model=%h",
                     name, diff_cnt, diff_cyc, diff_obs, diff_exp);
        end
        diff_cnt = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stb = '0; clr = '0; ack = 1'b0;
        auto_ack = 1'b0; rand_delay = 1'b0; ack_delay = 3; diff_cnt = 0;
        step();
        step();
        compared++;
        if (obs_vec() !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h want 0", obs_vec());
        end
        rst_n = 1'b1;
        step();
        compared++;
        if (obs_vec() !== '0) begin
            mismatched++;
            $display("FAIL reset_release_idle: got %h want 0", obs_vec());
        end
        model_ok("reset");
    endtask

    task automatic test_single();
        bit ok;
        auto_ack = 1'b1; ack_delay = 3; ack_cnt = 0;
        grants.delete(); dones = 0;
        stb = 4'b0100;
        step();
        compared++;
        if ({req, pending} !== {1'b0, 4'b0100}) begin
            mismatched++;
            $display("FAIL single_pending: req/pending got %b/%b want 0/0100", req, pending);
        end
        step();
        compared++;
        if ({req, id} !== {1'b1, 2'd2}) begin
            mismatched++;
            $display("FAIL single_grant: req/id got %b/%0d want 1/2", req, id);
        end
        drain(40, ok);
        compared++;
        if (!ok || dones != 1 || pending !== 4'b0000) begin
            mismatched++;
            $display("FAIL single_done: drained=%0b dones=%0d pending=%b want 1/1/0000",
                     ok, dones, pending);
        end
        model_ok("single");
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp_g[$];
        apply_reset();
        grants.delete(); dones = 0;
        stb = 4'b1111;
        step();
        drain(80, ok);
        exp_g = {0, 1, 2, 3};
        compared++;
        if (!ok || !same_q(grants, exp_g) || dones != 4) begin
            mismatched++;
            $display("FAIL rr_all: grants=%p dones=%0d drained=%0b want '{0,1,2,3}/4/1",
                     grants, dones, ok);
        end
        grants.delete(); dones = 0;
        stb = 4'b0011;
        step();
        drain(60, ok);
        exp_g = {0, 1};
        compared++;
        if (!ok || !same_q(grants, exp_g) || dones != 2) begin
            mismatched++;
            $display("FAIL rr_wrap: grants=%p dones=%0d drained=%0b want '{0,1}/2/1",
                     grants, dones, ok);
        end
        model_ok("round_robin");
    endtask

    task automatic test_overrun();
        bit ok;
        stb = 4'b0001; step();
        stb = 4'b0010; step();
        stb = 4'b0010; step();
        compared++;
        if (overrun !== 4'b0010) begin
            mismatched++;
            $display("FAIL overrun_set: got %b want 0010", overrun);
        end
        stb = 4'b0010; clr = 4'b0010; step();
        compared++;
        if (overrun !== 4'b0010) begin
            mismatched++;
            $display("FAIL overrun_set_wins: got %b want 0010", overrun);
        end
        clr = 4'b0010; step();
        compared++;
        if (overrun !== 4'b0000) begin
            mismatched++;
            $display("FAIL overrun_clear: got %b want 0000", overrun);
        end
        drain(60, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL overrun_drain: busy=%b pending=%b want idle/0000", busy, pending);
        end
        model_ok("overrun");
    endtask

    task automatic test_requeue();
        bit ok;
        int exp_g[$];
        grants.delete();
        stb = 4'b1000; step();
        stb = 4'b1000; step();
        compared++;
        if ({req, id, pending[3], overrun[3]} !== {1'b1, 2'd3, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL requeue_grant: req/id/pend3/ovr3 got %b/%0d/%b/%b want 1/3/1/0",
                     req, id, pending[3], overrun[3]);
        end
        drain(60, ok);
        exp_g = {3, 3};
        compared++;
        if (!ok || !same_q(grants, exp_g)) begin
            mismatched++;
            $display("FAIL requeue_second: grants=%p drained=%0b want '{3,3}/1", grants, ok);
        end
        model_ok("requeue");
    endtask

    task automatic test_stale_ack();
        bit ok;
        auto_ack = 1'b0;
        ack = 1'b1;
        stb = 4'b0001;
        step();
        repeat (3) step();
        compared++;
        if ({req, pending} !== {1'b0, 4'b0001}) begin
            mismatched++;
            $display("FAIL stale_hold: req/pending got %b/%b want 0/0001", req, pending);
        end
        ack = 1'b0;
        step();
        compared++;
        if ({req, id} !== {1'b1, 2'd0}) begin
            mismatched++;
            $display("FAIL stale_release: req/id got %b/%0d want 1/0", req, id);
        end
        ack_cnt = 0;
        auto_ack = 1'b1;
        drain(40, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL stale_drain: busy=%b pending=%b want idle/0000", busy, pending);
        end
        model_ok("stale_ack");
    endtask

    task automatic test_random();
        bit ok;
        apply_reset();
        rand_delay = 1'b1; ack_delay = 2; ack_cnt = 0;
        dones = 0; m_dones = 0;
        for (int i = 0; i < 600; i++) begin
            stb = NREQ'($urandom & $urandom & $urandom);
            clr = ($urandom_range(0, 5) == 0) ? NREQ'($urandom) : '0;
            step();
        end
        drain(300, ok);
        compared++;
        if (!ok || dones != m_dones) begin
            mismatched++;
            $display("FAIL random_dones: dut=%0d model=%0d drained=%0b", dones, m_dones, ok);
        end
        rand_delay = 1'b0; ack_delay = 3;
        model_ok("random");
    endtask

`ifdef CDC_EVENT_SCHEDULER_WATCHDOG_EN
    task automatic test_watchdog();
        int req_cycles;
        apply_reset();
        auto_ack = 1'b0; ack = 1'b0; dones = 0;
        stb = 4'b0001;
        step();
        step();
        req_cycles = (req === 1'b1) ? 1 : 0;
        for (int i = 0; i < 20 && req === 1'b1; i++) begin
            step();
            if (req === 1'b1) req_cycles++;
        end
        compared++;
        if (req_cycles != TIMEOUT || timeout !== 1'b1 || req !== 1'b0) begin
            mismatched++;
            $display("FAIL watchdog_req: req cycles=%0d timeout=%b req=%b want %0d/1/0",
                     req_cycles, timeout, req, TIMEOUT);
        end
        repeat (4) step();
        compared++;
        if (dones != 0 || busy !== 1'b0 || timeout !== 1'b0 || pending !== '0) begin
            mismatched++;
            $display("FAIL watchdog_abort: dones=%0d busy=%b timeout=%b pending=%b want 0/0/0/0000",
                     dones, busy, timeout, pending);
        end
        apply_reset();
        auto_ack = 1'b1; ack_cnt = 0;
        diff_cnt = 0;
    endtask
`endif

    task automatic test_reset_mid_req();
        auto_ack = 1'b0; ack = 1'b0;
        stb = 4'b0010;
        step();
        step();
        compared++;
        if ({req, id} !== {1'b1, 2'd1}) begin
            mismatched++;
            $display("FAIL midreq_setup: req/id got %b/%0d want 1/1", req, id);
        end
        stb = 4'b0100;
        rst_n = 1'b0;
        step();
        compared++;
        if (obs_vec() !== '0) begin
            mismatched++;
            $display("FAIL midreq_reset: got %h want 0", obs_vec());
        end
        rst_n = 1'b1;
        step();
        compared++;
        if (obs_vec() !== '0) begin
            mismatched++;
            $display("FAIL midreq_after: got %h want 0", obs_vec());
        end
        model_ok("reset_mid_req");
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_overrun();
        test_requeue();
        test_stale_ack();
        test_random();
`ifdef CDC_EVENT_SCHEDULER_WATCHDOG_EN
        test_watchdog();
`endif
        test_reset_mid_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/cdc_event_scheduler.md
Name: cdc_event_scheduler

Overview:
Source-domain scheduler that shares one four-phase req/ack clock-crossing channel among NREQ event requesters. Single-cycle input strobes are captured into sticky per-requester pending bits. A round-robin arbiter picks one pending requester and drives the req/ack handshake with the crossing. The requester ID is held stable on o_id for the whole transaction, so the destination side can decode which event arrived. i_ack is the destination acknowledgement, already synchronized into i_clk.

Parameters:
NREQ, 4, number of event requesters (2..16)
IDW, 2, width of o_id; must satisfy 2**IDW >= NREQ
TIMEOUT, 1023, watchdog limit in i_clk cycles (used only with the macro)
TOW, 10, watchdog counter width; must satisfy 2**TOW > TIMEOUT

Ports:
i_clk  in  1  clock; all logic on posedge
i_reset_n  in  1  synchronous reset, active-low
i_stb  in  NREQ  one-cycle event strobes, one bit per requester
i_clr_overrun  in  NREQ  per-bit clear of o_overrun
i_ack  in  1  synchronized acknowledge from the crossing
o_req  out  1  handshake request level
o_id  out  IDW  granted requester index; valid and stable while o_busy
o_busy  out  1  a handshake is in progress (state != IDLE)
o_done  out  1  one-cycle pulse when a handshake completes normally
o_pending  out  NREQ  sticky pending bits
o_overrun  out  NREQ  sticky lost-event flags
o_timeout  out  1  one-cycle watchdog abort pulse

Behaviour:
- Reset (i_reset_n=0 at a posedge):
  - outputs: o_req=0, o_id=0, o_busy=0, o_done=0, o_pending=0, o_overrun=0, o_timeout=0.
  - internal: rr pointer=0, state=IDLE, watchdog counter=0.
  - reset mid-handshake abandons the transaction; o_req drops on the next edge.
- Pending bits: pending[k] is set by i_stb[k]. It is cleared on the edge where k is granted (IDLE->REQ). If i_stb[k] arrives on its own grant edge, the set wins, so the event is queued again.
- Overrun:
  - o_overrun[k] sets when i_stb[k]=1 while pending[k]=1 and k is not being granted that edge.
  - i_clr_overrun[k] clears it; if set and clear occur together, set wins.
- Arbitration: round-robin over registered pending bits, searching from index ptr upward with wrap. After granting k, ptr becomes (k+1) mod NREQ.
- FSM:
  - IDLE: when pending!=0 and i_ack=0, latch o_id=winner and go to REQ. If i_ack=1 (stale ack), stay in IDLE.
  - REQ: o_req=1. When i_ack=1, go to RELEASE.
  - RELEASE: o_req=0. When i_ack=0, pulse o_done for one cycle and go to IDLE.
  - o_req is registered and equals (state==REQ).
- Latency:
  - i_stb at edge t -> pending at t+1 -> o_req=1 at t+2 (if idle and ack low).
  - Minimum handshake: 2 cycles of o_req per ack edge. Back-to-back grants are possible on the cycle after o_done.
- o_id changes only on an IDLE->REQ transition.

Optional Feature:
- Macro: CDC_EVENT_SCHEDULER_WATCHDOG_EN.
- Defined:
  - Counter clears on every state change and increments each cycle in REQ or RELEASE.
  - Reaching TIMEOUT in REQ: go to RELEASE (o_req drops) and pulse o_timeout.
  - Reaching TIMEOUT in RELEASE: force IDLE, pulse o_timeout, no o_done.
  - The aborted event is not re-queued.
- Undefined: no counter; the FSM waits indefinitely; o_timeout is tied to 0.

Decomposition:
- Package cdc_event_pkg holds:
  - FSM state encoding constants: ST_IDLE=2'b00, ST_REQ=2'b01, ST_RELEASE=2'b10.
  - A clog2 helper used for IDW/TOW checks.
- Sub-module rr_arbiter (param NREQ, IDW) holds the pointer and produces winner index plus any-valid. Its ptr updates on a grant input.
- FSM, pending, and overrun logic stay in the top module.

Test Plan:
- Single event: reset, then i_stb=4'b0100 for 1 cycle; ack responder delays 3 cycles.
  - o_req rises 2 cycles after the strobe, with o_id=2.
  - o_done pulses once; o_pending returns to 0.
- Round-robin: i_stb=4'b1111 in one cycle.
  - Grants come in order o_id=0,1,2,3 with exactly 4 o_done pulses.
  - Then i_stb=4'b0011: grants are 0 then 1 (ptr has wrapped to 0).
- Overrun: i_stb[1] twice while requester 1 is pending behind an active grant of 0.
  - o_overrun=4'b0010.
  - i_clr_overrun[1] together with a new overrun on 1 leaves the bit set; a clear alone resets it.
- Re-queue on grant: i_stb[3] on the same edge as grant of 3.
  - o_pending[3]=1 afterwards, with no overrun; a second transaction with o_id=3 follows.
- Stale ack: hold i_ack=1 with pending=4'b0001.
  - o_req stays 0 until i_ack falls, then rises the next cycle.
- Reset mid-REQ: assert i_reset_n=0 while o_req=1.
  - Next edge: all outputs 0.
  - With the WATCHDOG_EN macro and TIMEOUT=8, ack never arrives: o_timeout pulses 8 cycles into REQ, o_req drops, and no o_done is produced.
